// File: rtl/vx_issue_perf_ctrs_pkg.sv
// Shared definitions for the issue-stage performance counters.
//
// Contents:
//   NUM_ISSUE_CTRS - number of counters (8).
//   CTR_*          - counter indices. They are also the field order in the
//                    snapshot word, with index 0 in the LSBs.
//   ex_unit_e      - execute-unit select encoding. Codes 5..7 are reserved.
//   snap_state_e   - snapshot FSM states.
//
// PERF_CTR_BITS supplies the default counter width. It falls back to 32 when
// the build does not define it.

`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 32
`endif

package vx_issue_perf_ctrs_pkg;

  localparam int NUM_ISSUE_CTRS = 8;

  localparam int CTR_IBF = 0;
  localparam int CTR_SCB = 1;
  localparam int CTR_LSU = 2;
  localparam int CTR_CSR = 3;
  localparam int CTR_ALU = 4;
  localparam int CTR_FPU = 5;
  localparam int CTR_GPU = 6;
  localparam int CTR_DUP = 7;

  typedef enum logic [2:0] {
    EX_ALU = 3'd0,
    EX_LSU = 3'd1,
    EX_CSR = 3'd2,
    EX_FPU = 3'd3,
    EX_GPU = 3'd4
  } ex_unit_e;

  typedef enum logic {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/vx_issue_perf_ctrs_if.sv
// Bundles every signal between the issue pipeline and the perf-counter block.
//
// Signals:
//   Event inputs: ibf_valid/ready, scb_valid/ready, ex_valid/unit/ready and
//                 dup_access.
//   Control:      clr, a one-cycle pulse that zeroes all counters.
//   Counters:     the eight live counter values.
//   Snapshot:     snap_req, plus the snap_valid/snap_ready handshake that
//                 carries snap_data.
//
// Modports:
//   master - the pipeline side. It drives events and requests, and reads the
//            counters and the snapshot.
//   slave  - the counter block.

interface vx_issue_perf_ctrs_if #(
  parameter int CTR_BITS = `PERF_CTR_BITS,
  parameter int EX_BITS  = 3
);
  logic                  ibf_valid;
  logic                  ibf_ready;
  logic                  scb_valid;
  logic                  scb_ready;
  logic                  ex_valid;
  logic [EX_BITS-1:0]    ex_unit;
  logic                  ex_ready;
  logic                  dup_access;
  logic                  clr;

  logic [CTR_BITS-1:0]   ibf_stalls;
  logic [CTR_BITS-1:0]   scb_stalls;
  logic [CTR_BITS-1:0]   lsu_stalls;
  logic [CTR_BITS-1:0]   csr_stalls;
  logic [CTR_BITS-1:0]   alu_stalls;
  logic [CTR_BITS-1:0]   fpu_stalls;
  logic [CTR_BITS-1:0]   gpu_stalls;
  logic [CTR_BITS-1:0]   dup_accesses;

  logic                  snap_req;
  logic                  snap_valid;
  logic                  snap_ready;
  logic [8*CTR_BITS-1:0] snap_data;

  modport master (
    output ibf_valid, ibf_ready, scb_valid, scb_ready, ex_valid, ex_unit,
           ex_ready, dup_access, clr, snap_req, snap_ready,
    input  ibf_stalls, scb_stalls, lsu_stalls, csr_stalls, alu_stalls,
           fpu_stalls, gpu_stalls, dup_accesses, snap_valid, snap_data
  );

  modport slave (
    input  ibf_valid, ibf_ready, scb_valid, scb_ready, ex_valid, ex_unit,
           ex_ready, dup_access, clr, snap_req, snap_ready,
    output ibf_stalls, scb_stalls, lsu_stalls, csr_stalls, alu_stalls,
           fpu_stalls, gpu_stalls, dup_accesses, snap_valid, snap_data
  );
endinterface

// File: rtl/vx_issue_perf_ctrs_ctr.sv
// A single event counter.
//
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset (the port is named reset)
//   inc   - add one at the next edge
//   clr   - zero the counter at the next edge; clr wins over inc
//   value - current count
//
// Configuration macro PERF_CTR_SAT_EN:
//   defined   - the counter sticks at all-ones until clr or reset.
//   undefined - the counter wraps from all-ones to zero.

module vx_issue_perf_ctrs_ctr #(
  parameter int CTR_BITS = `PERF_CTR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [CTR_BITS-1:0] value
);

  logic [CTR_BITS-1:0] value_q;
  logic [CTR_BITS-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
`ifdef PERF_CTR_SAT_EN
      if (value_q != {CTR_BITS{1'b1}}) begin
        value_d = value_q + CTR_BITS'(1);
      end
`else
      value_d = value_q + CTR_BITS'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/vx_issue_perf_ctrs.sv
// Issue-stage performance counters.
//
// The block counts ibuffer, scoreboard, per-unit dispatch stalls and
// duplicate register-file accesses. It also offers a coherent snapshot of
// all eight counters.
//
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   perf  - vx_issue_perf_ctrs_if.slave. It carries the event inputs, clr,
//           the live counters and the snapshot handshake.
//
// Timing: an event is registered into a stage flop at edge N, and its
// counter moves at edge N+1.
//
// Configuration: PERF_CTR_SAT_EN (see vx_issue_perf_ctrs_ctr) selects
// saturating counters instead of wrapping ones.

module vx_issue_perf_ctrs
  import vx_issue_perf_ctrs_pkg::*;
#(
  parameter int CTR_BITS = `PERF_CTR_BITS,
  parameter int EX_BITS  = 3
) (
  input logic                 clk,
  input logic                 reset,
  vx_issue_perf_ctrs_if.slave perf
);

  logic [NUM_ISSUE_CTRS-1:0]          events_d;
  logic [NUM_ISSUE_CTRS-1:0]          events_q;
  logic [CTR_BITS-1:0]                ctr_value [NUM_ISSUE_CTRS];
  logic [NUM_ISSUE_CTRS*CTR_BITS-1:0] live_packed;
  logic [NUM_ISSUE_CTRS*CTR_BITS-1:0] snap_data_d;
  logic [NUM_ISSUE_CTRS*CTR_BITS-1:0] snap_data_q;
  snap_state_e                        state_d;
  snap_state_e                        state_q;

  // Decode this cycle's events. A unit stall is charged to the selected
  // unit only. Reserved unit codes fall through and count nowhere.
  always_comb begin
    events_d          = '0;
    events_d[CTR_IBF] = perf.ibf_valid & ~perf.ibf_ready;
    events_d[CTR_SCB] = perf.scb_valid & ~perf.scb_ready;
    events_d[CTR_DUP] = perf.dup_access;
    if (perf.ex_valid & ~perf.ex_ready) begin
      case (perf.ex_unit)
        EX_BITS'(EX_ALU): events_d[CTR_ALU] = 1'b1;
        EX_BITS'(EX_LSU): events_d[CTR_LSU] = 1'b1;
        EX_BITS'(EX_CSR): events_d[CTR_CSR] = 1'b1;
        EX_BITS'(EX_FPU): events_d[CTR_FPU] = 1'b1;
        EX_BITS'(EX_GPU): events_d[CTR_GPU] = 1'b1;
        default: ;
      endcase
    end
  end

  // The stage always loads, even on clr. The counters ignore the stage
  // during clr, so stale events are dropped. Events that arrive together
  // with clr still land in the stage and are counted after the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      events_q <= '0;
    end else begin
      events_q <= events_d;
    end
  end

  for (genvar i = 0; i < NUM_ISSUE_CTRS; i++) begin : g_ctr
    vx_issue_perf_ctrs_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (events_q[i]),
      .clr   (perf.clr),
      .value (ctr_value[i])
    );
  end

  always_comb begin
    live_packed = '0;
    for (int i = 0; i < NUM_ISSUE_CTRS; i++) begin
      live_packed[i*CTR_BITS +: CTR_BITS] = ctr_value[i];
    end
  end

  // Snapshot FSM. The capture uses the registered counter values, so a
  // capture that coincides with clr still sees the pre-clear counts.
  always_comb begin
    state_d     = state_q;
    snap_data_d = snap_data_q;
    case (state_q)
      SNAP_IDLE: begin
        if (perf.snap_req) begin
          state_d     = SNAP_HOLD;
          snap_data_d = live_packed;
        end
      end
      SNAP_HOLD: begin
        if (perf.snap_ready) begin
          state_d = SNAP_IDLE;
        end
      end
      default: state_d = SNAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SNAP_IDLE;
      snap_data_q <= '0;
    end else begin
      state_q     <= state_d;
      snap_data_q <= snap_data_d;
    end
  end

  assign perf.ibf_stalls   = ctr_value[CTR_IBF];
  assign perf.scb_stalls   = ctr_value[CTR_SCB];
  assign perf.lsu_stalls   = ctr_value[CTR_LSU];
  assign perf.csr_stalls   = ctr_value[CTR_CSR];
  assign perf.alu_stalls   = ctr_value[CTR_ALU];
  assign perf.fpu_stalls   = ctr_value[CTR_FPU];
  assign perf.gpu_stalls   = ctr_value[CTR_GPU];
  assign perf.dup_accesses = ctr_value[CTR_DUP];
  assign perf.snap_valid   = (state_q == SNAP_HOLD);
  assign perf.snap_data    = snap_data_q;

endmodule

// File: tb/tb_vx_issue_perf_ctrs.sv
// Self-checking bench for vx_issue_perf_ctrs.
//
// Two instances are used. The first is 32 bits wide and takes the vector
// table, the directed sequences and a randomized run against a
// history-based reference model. The second is 4 bits wide and is used for
// the wrap/saturate boundary.

module tb_vx_issue_perf_ctrs;
  import vx_issue_perf_ctrs_pkg::*;

  localparam int W  = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic       iv;
    logic       ir;
    logic       sv;
    logic       sr;
    logic       xv;
    logic [2:0] xu;
    logic       xr;
    logic       dp;
  } stim_t;

  typedef struct {
    stim_t      in;
    logic [7:0] exp_inc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_compared = 0;
  int   n_mismatched = 0;

  string      ctr_name [8] = '{"ibf", "scb", "lsu", "csr", "alu", "fpu", "gpu", "dup"};
  logic [W-1:0] want [8];

  vec_t       vecs [$];
  logic [7:0] hist [$];
  logic [W-1:0] exp_ctr  [8];
  logic [W-1:0] exp_snap [8];
  bit           exp_hold;

  always #5 clk = ~clk;

  vx_issue_perf_ctrs_if #(.CTR_BITS(W),  .EX_BITS(3)) bus   ();
  vx_issue_perf_ctrs_if #(.CTR_BITS(SW), .EX_BITS(3)) bus_s ();

  vx_issue_perf_ctrs #(.CTR_BITS(W), .EX_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .perf  (bus)
  );

  vx_issue_perf_ctrs #(.CTR_BITS(SW), .EX_BITS(3)) dut_s (
    .clk   (clk),
    .reset (reset),
    .perf  (bus_s)
  );

  function automatic stim_t mk(logic iv, logic ir, logic sv, logic sr,
                               logic xv, logic [2:0] xu, logic xr, logic dp);
    stim_t s;
    s.iv = iv; s.ir = ir; s.sv = sv; s.sr = sr;
    s.xv = xv; s.xu = xu; s.xr = xr; s.dp = dp;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 3'd0, 0, 0);
  endfunction

  // Event vector written straight from the event definitions.
  function automatic logic [7:0] events_of(stim_t s);
    logic [7:0] ev = 8'h00;
    ev[0] = s.iv && !s.ir;
    ev[1] = s.sv && !s.sr;
    ev[7] = s.dp;
    if (s.xv && !s.xr) begin
      if (s.xu == 3'd0) ev[4] = 1'b1;
      if (s.xu == 3'd1) ev[2] = 1'b1;
      if (s.xu == 3'd2) ev[3] = 1'b1;
      if (s.xu == 3'd3) ev[5] = 1'b1;
      if (s.xu == 3'd4) ev[6] = 1'b1;
    end
    return ev;
  endfunction

  function automatic logic [W-1:0] live_ctr(int k);
    case (k)
      0: return bus.ibf_stalls;
      1: return bus.scb_stalls;
      2: return bus.lsu_stalls;
      3: return bus.csr_stalls;
      4: return bus.alu_stalls;
      5: return bus.fpu_stalls;
      6: return bus.gpu_stalls;
      default: return bus.dup_accesses;
    endcase
  endfunction

  task automatic applyStimulus(input stim_t s, input bit clr, input bit snap_req, input bit snap_ready);
    bus.ibf_valid  = s.iv;
    bus.ibf_ready  = s.ir;
    bus.scb_valid  = s.sv;
    bus.scb_ready  = s.sr;
    bus.ex_valid   = s.xv;
    bus.ex_unit    = s.xu;
    bus.ex_ready   = s.xr;
    bus.dup_access = s.dp;
    bus.clr        = clr;
    bus.snap_req   = snap_req;
    bus.snap_ready = snap_ready;
  endtask

  task automatic drive_small(input bit scb_stall);
    bus_s.ibf_valid  = 1'b0;
    bus_s.ibf_ready  = 1'b0;
    bus_s.scb_valid  = scb_stall;
    bus_s.scb_ready  = 1'b0;
    bus_s.ex_valid   = 1'b0;
    bus_s.ex_unit    = 3'd0;
    bus_s.ex_ready   = 1'b0;
    bus_s.dup_access = 1'b0;
    bus_s.clr        = 1'b0;
    bus_s.snap_req   = 1'b0;
    bus_s.snap_ready = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ctrs(input string tag);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s.%s", tag, ctr_name[k]), 64'(live_ctr(k)), 64'(want[k]));
    end
  endtask

  task automatic set_want(input logic [7:0] bits);
    for (int k = 0; k < 8; k++) want[k] = W'(bits[k]);
  endtask

  task automatic clear_ctrs();
    applyStimulus(idle(), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model. The count after an edge equals the number of event
  // samples taken at earlier edges since the most recent clear. The clear
  // edge's own sample is included, but only from the next edge on.
  task automatic model_reset();
    hist.delete();
    exp_hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_ctr[k]  = '0;
      exp_snap[k] = '0;
    end
  endtask

  task automatic model_edge(input stim_t s, input bit clr, input bit snap_req, input bit snap_ready);
    logic [W-1:0] prev [8];
    longint sum;
    for (int k = 0; k < 8; k++) prev[k] = exp_ctr[k];
    if (clr) hist.delete();
    for (int k = 0; k < 8; k++) begin
      sum = 0;
      foreach (hist[i]) sum += longint'(hist[i][k]);
`ifdef PERF_CTR_SAT_EN
      if (sum > longint'({W{1'b1}})) sum = longint'({W{1'b1}});
`endif
      exp_ctr[k] = W'(sum);
    end
    hist.push_back(events_of(s));
    if (!exp_hold && snap_req) begin
      exp_hold = 1'b1;
      for (int k = 0; k < 8; k++) exp_snap[k] = prev[k];
    end else if (exp_hold && snap_ready) begin
      exp_hold = 1'b0;
    end
  endtask

  initial begin
    stim_t s;
    bit    r_clr, r_req, r_rdy;
    bit    seen;
    logic [63:0] small_exp;

    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    drive_small(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    set_want(8'h00);
    check_ctrs("reset");
    checkOutput("reset.snap_valid", 64'(bus.snap_valid), 64'd0);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("reset.snap_%s", ctr_name[k]), 64'(bus.snap_data[k*W +: W]), 64'd0);

    // Single-cycle event vectors
    vecs.push_back('{mk(1, 0, 0, 0, 0, 3'd0, 0, 0), 8'h01});
    vecs.push_back('{mk(1, 1, 0, 0, 0, 3'd0, 0, 0), 8'h00});
    vecs.push_back('{mk(0, 0, 1, 0, 0, 3'd0, 0, 0), 8'h02});
    vecs.push_back('{mk(0, 0, 1, 1, 0, 3'd0, 0, 0), 8'h00});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd0, 0, 0), 8'h10});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd1, 0, 0), 8'h04});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd2, 0, 0), 8'h08});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd3, 0, 0), 8'h20});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd4, 0, 0), 8'h40});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd5, 0, 0), 8'h00});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd7, 0, 0), 8'h00});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 3'd1, 1, 0), 8'h00});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 3'd1, 0, 0), 8'h00});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 3'd0, 0, 1), 8'h80});
    vecs.push_back('{mk(1, 0, 1, 0, 1, 3'd4, 0, 1), 8'hC3});
    for (int i = 0; i < vecs.size(); i++) begin
      clear_ctrs();
      applyStimulus(vecs[i].in, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
      set_want(8'h00);
      check_ctrs($sformatf("vec%0d_staged", i));
      @(negedge clk);
      set_want(vecs[i].exp_inc);
      check_ctrs($sformatf("vec%0d", i));
    end

    // Five ibuffer stalls; two-edge latency
    clear_ctrs();
    applyStimulus(mk(1, 0, 0, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    checkOutput("ibf5.latency", 64'(bus.ibf_stalls), 64'd4);
    @(negedge clk);
    set_want(8'h00);
    want[CTR_IBF] = W'(5);
    check_ctrs("ibf5");

    // LSU stalls, then reserved unit code
    clear_ctrs();
    applyStimulus(mk(0, 0, 0, 0, 1, 3'd1, 0, 0), 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(mk(0, 0, 0, 0, 1, 3'd6, 0, 0), 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    set_want(8'h00);
    want[CTR_LSU] = W'(3);
    check_ctrs("lsu3");

    // clr while dup_access stays high
    clear_ctrs();
    applyStimulus(mk(0, 0, 0, 0, 0, 3'd0, 0, 1), 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("dup.before_clr", 64'(bus.dup_accesses), 64'd2);
    applyStimulus(mk(0, 0, 0, 0, 0, 3'd0, 0, 1), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dup.clr_edge", 64'(bus.dup_accesses), 64'd0);
    applyStimulus(mk(0, 0, 0, 0, 0, 3'd0, 0, 1), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dup.resume1", 64'(bus.dup_accesses), 64'd1);
    @(negedge clk);
    checkOutput("dup.resume2", 64'(bus.dup_accesses), 64'd2);

    // Snapshot held while counting continues
    clear_ctrs();
    applyStimulus(mk(0, 0, 1, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (bus.scb_stalls == W'(7)) seen = 1'b1;
    end
    checkOutput("snap.reach7", 64'(seen), 64'd1);
    applyStimulus(mk(0, 0, 1, 0, 0, 3'd0, 0, 0), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("snap.hold%0d.valid", k), 64'(bus.snap_valid), 64'd1);
      checkOutput($sformatf("snap.hold%0d.scb", k), 64'(bus.snap_data[CTR_SCB*W +: W]), 64'd7);
      checkOutput($sformatf("snap.hold%0d.live", k), 64'(bus.scb_stalls), 64'(8 + k));
      applyStimulus(mk(0, 0, 1, 0, 0, 3'd0, 0, 0), 1'b0, (k == 1), 1'b0);
      @(negedge clk);
    end
    applyStimulus(mk(0, 0, 1, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("snap.release", 64'(bus.snap_valid), 64'd0);

    // snap_req together with clr captures pre-clear values
    clear_ctrs();
    applyStimulus(mk(0, 0, 1, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(idle(), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b1);
    checkOutput("snapclr.snap_scb", 64'(bus.snap_data[CTR_SCB*W +: W]), 64'd3);
    checkOutput("snapclr.live_scb", 64'(bus.scb_stalls), 64'd0);
    checkOutput("snapclr.valid", 64'(bus.snap_valid), 64'd1);
    @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    checkOutput("snapclr.release", 64'(bus.snap_valid), 64'd0);

    // Narrow counter boundary: 20 stalls into 4 bits
    drive_small(1'b1);
    repeat (20) @(negedge clk);
    drive_small(1'b0);
    repeat (2) @(negedge clk);
`ifdef PERF_CTR_SAT_EN
    small_exp = 64'd15;
`else
    small_exp = 64'd4;
`endif
    checkOutput("narrow.scb", 64'(bus_s.scb_stalls), small_exp);

    // Reset while holding a snapshot
    clear_ctrs();
    applyStimulus(mk(1, 0, 0, 0, 0, 3'd0, 0, 1), 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle(), 1'b0, 1'b0, 1'b0);
    checkOutput("rsthold.pre_valid", 64'(bus.snap_valid), 64'd1);
    checkOutput("rsthold.pre_ibf", 64'(bus.ibf_stalls), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    set_want(8'h00);
    check_ctrs("rsthold");
    checkOutput("rsthold.valid", 64'(bus.snap_valid), 64'd0);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("rsthold.snap_%s", ctr_name[k]), 64'(bus.snap_data[k*W +: W]), 64'd0);
    checkOutput("rsthold.narrow", 64'(bus_s.scb_stalls), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the reference model
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++)
        checkOutput($sformatf("rand%0d.%s", cyc, ctr_name[k]), 64'(live_ctr(k)), 64'(exp_ctr[k]));
      checkOutput($sformatf("rand%0d.snap_valid", cyc), 64'(bus.snap_valid), 64'(exp_hold));
      if (exp_hold) begin
        for (int k = 0; k < 8; k++)
          checkOutput($sformatf("rand%0d.snap_%s", cyc, ctr_name[k]),
                      64'(bus.snap_data[k*W +: W]), 64'(exp_snap[k]));
      end
      s = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      r_clr = ($urandom_range(0, 49) == 0);
      r_req = ($urandom_range(0, 5) == 0);
      r_rdy = ($urandom_range(0, 2) == 0);
      applyStimulus(s, r_clr, r_req, r_rdy);
      @(posedge clk);
      model_edge(s, r_clr, r_req, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/vx_issue_perf_ctrs.md
VX_ISSUE_PERF_CTRS -- requirements
Module: VX_issue_perf_ctrs

Interface
REQ-001 SHALL have parameter CTR_BITS, default `PERF_CTR_BITS, the width of every counter.
REQ-002 SHALL have parameter EX_BITS, default 3, the width of the execute-unit select.
REQ-003 clk  in  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ibf_valid  in  1  issue stage holds an instruction in its ibuffer.
REQ-006 ibf_ready  in  1  ibuffer entry is dequeued this cycle.
REQ-007 scb_valid  in  1  instruction is presented to the scoreboard.
REQ-008 scb_ready  in  1  scoreboard grants the instruction.
REQ-009 ex_valid  in  1  dispatch is presenting to an execute unit.
REQ-010 ex_unit  in  EX_BITS  target unit: 0 ALU, 1 LSU, 2 CSR, 3 FPU, 4 GPU; other codes are reserved.
REQ-011 ex_ready  in  1  target unit accepts.
REQ-012 dup_access  in  1  duplicate register-file access this cycle.
REQ-013 clr  in  1  one-cycle request that zeroes all counters.
REQ-014 ibf_stalls, scb_stalls, lsu_stalls, csr_stalls, alu_stalls, fpu_stalls, gpu_stalls, dup_accesses  out  CTR_BITS each  live counter values, driving the issue modport of the pipeline perf interface.
REQ-015 snap_req  in  1  request to capture all eight counters coherently.
REQ-016 snap_valid  out  1  snapshot held and available.
REQ-017 snap_ready  in  1  consumer accepts the snapshot.
REQ-018 snap_data  out  8*CTR_BITS  snapshot, packed in index order ibf, scb, lsu, csr, alu, fpu, gpu, dup (index 0 in the LSBs).

Function
REQ-019 Event definitions:
- ibf stall = ibf_valid & ~ibf_ready
- scb stall = scb_valid & ~scb_ready
- unit stall = ex_valid & ~ex_ready, counted against the unit selected by ex_unit
- dup event = dup_access
REQ-020 Reserved ex_unit codes SHALL increment no counter.
REQ-021 Events SHALL be registered in an input stage at edge N; the affected counter SHALL increment by exactly 1 at edge N+1.
REQ-022 Observed latency from event to visible output change SHALL be 2 edges.
REQ-023 clr sampled at edge N SHALL zero every counter at edge N and discard any events already staged.
REQ-024 An event sampled together with clr SHALL be counted after the clear.
REQ-025 Snapshot FSM SHALL have two states:
- IDLE: snap_req moves to HOLD, captures the live counter values at that edge, and sets snap_valid.
- HOLD: snap_valid & snap_ready returns to IDLE.
REQ-026 snap_req SHALL be ignored while in HOLD.
REQ-027 snap_data SHALL be stable while in HOLD.
REQ-028 snap_req and clr at the same edge SHALL capture the pre-clear values.
REQ-029 Counters SHALL keep counting regardless of snapshot state.

Reset
REQ-030 Reset SHALL set all counters, the staged events, and snap_data to 0, clear snap_valid, and return the FSM to IDLE.
REQ-031 Reset mid-HOLD SHALL drop the pending snapshot without a handshake.

Configuration
REQ-032 With PERF_CTR_SAT_EN defined, each counter SHALL saturate at all-ones and hold that value until clr or reset.
REQ-033 Without PERF_CTR_SAT_EN, counters SHALL wrap from all-ones to 0.

Structure
REQ-034 VX_perf_pkg SHALL hold the ex_unit encoding enum, the counter index constants, and NUM_ISSUE_CTRS=8.
REQ-035 One sub-module, VX_perf_ctr (inc, clr, value, saturate or wrap), SHALL be instantiated eight times.

Verification
REQ-036 After reset, hold ibf_valid=1 and ibf_ready=0 for 5 cycles -> ibf_stalls reads 5 two edges after the last event; all other counters read 0.
REQ-037 Drive ex_valid=1, ex_ready=0, ex_unit=1 for 3 cycles, then ex_unit=6 for 2 cycles -> lsu_stalls=3; all unit counters otherwise 0.
REQ-038 With dup_access=1 continuously, pulse clr -> dup_accesses reads 0 on the clr edge, then resumes counting from 1.
REQ-039 Raise snap_req with scb_stalls=7 and snap_ready held 0 for 4 cycles while stalls continue -> snap_data scb field stays 7 and the live counter keeps rising; a second snap_req during this window is ignored; snap_ready=1 -> snap_valid falls.
REQ-040 With CTR_BITS=4, apply 20 scb stall cycles -> scb_stalls reads 15 with PERF_CTR_SAT_EN defined, or 4 without it.
REQ-041 Assert reset in HOLD with nonzero counters -> all outputs read 0 immediately and snap_valid=0.
